chroma_line_buf: RTL and testbench



---
 rtl/chroma_lb_pkg.sv | 8 +
 rtl/chroma_lb_ram.sv | 30 +++
 rtl/chroma_line_buf.sv | 78 +++++++
 tb/tb_chroma_line_buf.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/chroma_lb_pkg.sv
// Shared constants for the chroma line buffer: DDR word geometry and default depth.
package chroma_lb_pkg;
  localparam int DDR_WORD_W          = 64;
  localparam int BYTE_W              = 8;
  localparam int BYTES_PER_WORD      = DDR_WORD_W / BYTE_W;
  localparam int LANE_W              = 3;
  localparam int DEFAULT_DEPTH_WORDS = 32;
endpackage

// File: rtl/chroma_lb_ram.sv
// Generic simple dual-port RAM: one write port, one registered read-first read port.
// The read register has a synchronous clear so the output can be forced to zero.
module chroma_lb_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rd_rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Non-blocking update means a same-address read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (rd_rst_i) rdata_q <= '0;
    else          rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/chroma_line_buf.sv
// Chroma line buffer: sequential 64-bit DDR word fill, byte-addressed registered read.
// Define CHROMA_LB_BIG_ENDIAN_EN to map byte lane 0 to wdata[63:56] instead of wdata[7:0].
module chroma_line_buf
  import chroma_lb_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DDR_WORD_W-1:0]                 wdata,
  input  logic                                  we,
  input  logic [$clog2(DEPTH_WORDS)+LANE_W-1:0] raddr,
  output logic [BYTE_W-1:0]                     q,
  output logic [$clog2(DEPTH_WORDS+1)-1:0]      wr_count,
  output logic                                  full,
  output logic                                  overflow
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(DEPTH_WORDS + 1);

  logic [CW-1:0]         wr_count_q, wr_count_d;
  logic                  overflow_q, overflow_d;
  logic [LANE_W-1:0]     lane_q;
  logic                  full_w;
  logic                  wr_en;
  logic [DDR_WORD_W-1:0] rd_word;
  logic [BYTE_W-1:0]     lane_bytes [BYTES_PER_WORD];

  assign full_w = (wr_count_q == CW'(DEPTH_WORDS));
  assign wr_en  = we && !full_w && !reset;

  always_comb begin
    wr_count_d = wr_count_q;
    overflow_d = overflow_q;
    if (wr_en)        wr_count_d = wr_count_q + CW'(1);
    if (we && full_w) overflow_d = 1'b1;
  end

  // Lane select is delayed to line up with the RAM's registered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count_q <= '0;
      overflow_q <= 1'b0;
      lane_q     <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      overflow_q <= overflow_d;
      lane_q     <= raddr[LANE_W-1:0];
    end
  end

  chroma_lb_ram #(
    .DATA_W (DDR_WORD_W),
    .DEPTH  (DEPTH_WORDS),
    .ADDR_W (AW)
  ) u_ram (
    .clk      (clk),
    .rd_rst_i (reset),
    .we_i     (wr_en),
    .waddr_i  (wr_count_q[AW-1:0]),
    .wdata_i  (wdata),
    .raddr_i  (raddr[AW+LANE_W-1:LANE_W]),
    .rdata_o  (rd_word)
  );

  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
`ifdef CHROMA_LB_BIG_ENDIAN_EN
    assign lane_bytes[gi] = rd_word[DDR_WORD_W-1-BYTE_W*gi -: BYTE_W];
`else
    assign lane_bytes[gi] = rd_word[BYTE_W*gi +: BYTE_W];
`endif
  end

  assign q        = lane_bytes[lane_q];
  assign wr_count = wr_count_q;
  assign full     = full_w;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_chroma_line_buf.sv
// Randomized self-checking bench for chroma_line_buf against a byte-array reference model.
module tb_chroma_line_buf;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] wdata;
  logic        we;
  logic [7:0]  raddr;
  logic [7:0]  q;
  logic [5:0]  wr_count;
  logic        full;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer seen as 256 bytes plus a word counter.
  logic [7:0] model_mem   [256];
  bit         model_known [256];
  int         model_cnt = 0;
  bit         model_ovf = 0;

  chroma_line_buf dut (
    .clk      (clk),
    .reset    (reset),
    .wdata    (wdata),
    .we       (we),
    .raddr    (raddr),
    .q        (q),
    .wr_count (wr_count),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [63:0] w, input int k);
`ifdef CHROMA_LB_BIG_ENDIAN_EN
    return w[8*(7-k) +: 8];
`else
    return w[8*k +: 8];
`endif
  endfunction

  // One clock of stimulus; outputs checked at the following falling edge.
  task automatic cycle(input bit rst_v, input bit we_v, input logic [63:0] wd, input logic [7:0] ra);
    logic [7:0] exp_q;
    bit         q_known;
    reset = rst_v;
    we    = we_v;
    wdata = wd;
    raddr = ra;
    if (rst_v) begin
      exp_q   = 8'h00;
      q_known = 1'b1;
    end else begin
      exp_q   = model_mem[ra];
      q_known = model_known[ra];
    end
    if (rst_v) begin
      model_cnt = 0;
      model_ovf = 1'b0;
    end else if (we_v) begin
      if (model_cnt == 32) model_ovf = 1'b1;
      else begin
        for (int k = 0; k < 8; k++) begin
          model_mem[model_cnt*8 + k]   = byte_of(wd, k);
          model_known[model_cnt*8 + k] = 1'b1;
        end
        model_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    $display("txn rst=%0d we=%0d wdata=%016h raddr=%0d -> q=%02h wr_count=%0d full=%0d ovf=%0d",
             rst_v, we_v, wd, ra, q, wr_count, full, overflow);
    if (q_known) check_eq("q", {56'd0, q}, {56'd0, exp_q});
    check_eq("wr_count", {58'd0, wr_count}, 64'(model_cnt));
    check_eq("full", {63'd0, full}, {63'd0, model_cnt == 32});
    check_eq("overflow", {63'd0, overflow}, {63'd0, model_ovf});
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] w;
    reset = 1'b1; we = 1'b0; wdata = '0; raddr = '0;
    @(negedge clk);

    // Reset state
    cycle(1, 0, 64'd0, 8'd0);
    cycle(1, 1, rand64(), 8'd3);
    check_eq("reset_q", {56'd0, q}, 64'd0);
    check_eq("reset_wr_count", {58'd0, wr_count}, 64'd0);

    // Sequential fill of 23 words, then sweep the 184 pixel bytes
    for (int i = 0; i < 23; i++) begin
      w = 64'h0706050403020100 + 64'h0808080808080808 * i;
      cycle(0, 1, w, 8'($urandom_range(0, 255)));
    end
    check_eq("fill_count", {58'd0, wr_count}, 64'd23);
    check_eq("fill_full", {63'd0, full}, 64'd0);
    for (int a = 0; a < 184; a++) begin
      cycle(0, 0, rand64(), 8'(a));
`ifndef CHROMA_LB_BIG_ENDIAN_EN
      check_eq("seq_byte", {56'd0, q}, 64'(a));
`endif
    end

    // Read-first collision on word 5 / raddr 40
    cycle(1, 0, 64'd0, 8'd0);
    for (int i = 0; i < 5; i++) cycle(0, 1, rand64(), 8'($urandom_range(0, 255)));
    cycle(0, 1, 64'hAAAAAAAAAAAAAAAA, 8'd40);
`ifndef CHROMA_LB_BIG_ENDIAN_EN
    check_eq("collision_old", {56'd0, q}, 64'd40);
`else
    check_eq("collision_old", {56'd0, q}, 64'd47);
`endif
    cycle(0, 0, 64'd0, 8'd40);
    check_eq("collision_new", {56'd0, q}, 64'hAA);

    // Fill to capacity, then one write too many
    while (model_cnt < 32) cycle(0, 1, rand64(), 8'($urandom_range(0, 255)));
    check_eq("cap_full", {63'd0, full}, 64'd1);
    cycle(0, 1, rand64(), 8'd0);
    check_eq("cap_count", {58'd0, wr_count}, 64'd32);
    check_eq("cap_overflow", {63'd0, overflow}, 64'd1);
    for (int a = 0; a < 8; a++) cycle(0, 0, 64'd0, 8'(a));

    // Reset together with a write mid-burst
    cycle(1, 0, 64'd0, 8'd0);
    for (int i = 0; i < 10; i++) cycle(0, 1, rand64(), 8'($urandom_range(0, 255)));
    cycle(1, 1, rand64(), 8'd0);
    check_eq("midrst_count", {58'd0, wr_count}, 64'd0);
    check_eq("midrst_ovf", {63'd0, overflow}, 64'd0);
    cycle(0, 1, 64'h1122334455667788, 8'd9);
    cycle(0, 0, 64'd0, 8'd0);
`ifndef CHROMA_LB_BIG_ENDIAN_EN
    check_eq("midrst_byte0", {56'd0, q}, 64'h88);
`else
    check_eq("midrst_byte0", {56'd0, q}, 64'h11);
`endif

    // Byte order
    cycle(1, 0, 64'd0, 8'd0);
    cycle(0, 1, 64'h0102030405060708, 8'd200);
    cycle(0, 0, 64'd0, 8'd0);
`ifndef CHROMA_LB_BIG_ENDIAN_EN
    check_eq("endian_lane0", {56'd0, q}, 64'h08);
`else
    check_eq("endian_lane0", {56'd0, q}, 64'h01);
`endif
    cycle(0, 0, 64'd0, 8'd7);
`ifndef CHROMA_LB_BIG_ENDIAN_EN
    check_eq("endian_lane7", {56'd0, q}, 64'h01);
`else
    check_eq("endian_lane7", {56'd0, q}, 64'h08);
`endif

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), rand64(),
            8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
